// File: rtl/reorder_buffer.sv
// Reorder buffer: circular queue of in-flight instructions that retires results in program order,
// with out-of-order writeback, youngest-producer operand forwarding and exception/flush recovery.
module reorder_buffer #(
    parameter int ROB_ENTRIES     = 8,
    parameter int ROB_ENTRY_WIDTH = $clog2(ROB_ENTRIES),
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,

    input  logic                       alloc_valid_i,
    output logic                       alloc_ready_o,
    input  logic [4:0]                 alloc_rd_i,
    input  logic [ADDR_WIDTH-1:0]      alloc_pc_i,
    input  logic                       alloc_is_store_i,
    output logic [ROB_ENTRY_WIDTH-1:0] alloc_tag_o,

    input  logic                       wb_valid_i,
    input  logic [ROB_ENTRY_WIDTH-1:0] wb_tag_i,
    input  logic [DATA_WIDTH-1:0]      wb_data_i,
    input  logic                       wb_exc_i,

    input  logic [4:0]                 lookup_rs_i,
    output logic                       lookup_hit_o,
    output logic                       lookup_ready_o,
    output logic [DATA_WIDTH-1:0]      lookup_data_o,

    output logic                       commit_valid_o,
    input  logic                       commit_ready_i,
    output logic [4:0]                 commit_rd_o,
    output logic [DATA_WIDTH-1:0]      commit_data_o,
    output logic [ADDR_WIDTH-1:0]      commit_pc_o,
    output logic                       commit_is_store_o,
    output logic                       commit_exc_o,

    input  logic                       flush_i,

    output logic [ROB_ENTRY_WIDTH:0]   count_o,
    output logic                       empty_o,
    output logic                       full_o
);

    localparam int CNT_W = ROB_ENTRY_WIDTH + 1;

    typedef enum logic [1:0] {
        ENT_FREE    = 2'd0,
        ENT_PENDING = 2'd1,
        ENT_DONE    = 2'd2
    } ent_state_e;

    ent_state_e                 ent_state     [ROB_ENTRIES];
    ent_state_e                 ent_state_nxt [ROB_ENTRIES];
    logic [4:0]                 ent_rd        [ROB_ENTRIES];
    logic [ADDR_WIDTH-1:0]      ent_pc        [ROB_ENTRIES];
    logic                       ent_is_store  [ROB_ENTRIES];
    logic [DATA_WIDTH-1:0]      ent_data      [ROB_ENTRIES];
    logic                       ent_exc       [ROB_ENTRIES];

    logic [ROB_ENTRY_WIDTH-1:0] head, head_nxt;
    logic [ROB_ENTRY_WIDTH-1:0] tail, tail_nxt;
    logic [CNT_W-1:0]           count, count_nxt;
    logic [ROB_ENTRY_WIDTH-1:0] lk_idx;

    logic alloc_fire;
    logic commit_fire;
    logic wb_fire;
    logic flush_all;

    assign full_o        = (count == CNT_W'(ROB_ENTRIES));
    assign empty_o       = (count == '0);
    assign count_o       = count;
    assign alloc_ready_o = !full_o;
    assign alloc_tag_o   = tail;

    assign commit_valid_o    = (ent_state[head] == ENT_DONE);
    assign commit_rd_o       = ent_rd[head];
    assign commit_data_o     = ent_data[head];
    assign commit_pc_o       = ent_pc[head];
    assign commit_is_store_o = ent_is_store[head];
    assign commit_exc_o      = ent_exc[head];

    assign commit_fire = commit_valid_o && commit_ready_i;
    // A retiring exception throws away everything younger, exactly like an external flush.
    assign flush_all   = flush_i || (commit_fire && commit_exc_o);
    // Full blocks alloc even when the head retires this cycle: no same-cycle slot reuse.
    assign alloc_fire  = alloc_valid_i && alloc_ready_o && !flush_all;
    // Only PENDING entries accept results; the head being retired is already DONE.
    assign wb_fire     = wb_valid_i && (ent_state[wb_tag_i] == ENT_PENDING) && !flush_all;

    always_comb begin
        for (int i = 0; i < ROB_ENTRIES; i++) begin
            ent_state_nxt[i] = ent_state[i];
        end
        head_nxt  = head;
        tail_nxt  = tail;
        count_nxt = count;

        if (flush_all) begin
            for (int i = 0; i < ROB_ENTRIES; i++) begin
                ent_state_nxt[i] = ENT_FREE;
            end
            head_nxt  = '0;
            tail_nxt  = '0;
            count_nxt = '0;
        end else begin
            if (wb_fire) begin
                ent_state_nxt[wb_tag_i] = ENT_DONE;
            end
            if (commit_fire) begin
                ent_state_nxt[head] = ENT_FREE;
                head_nxt            = head + 1'b1;
            end
            if (alloc_fire) begin
                ent_state_nxt[tail] = ENT_PENDING;
                tail_nxt            = tail + 1'b1;
            end
            case ({alloc_fire, commit_fire})
                2'b10:   count_nxt = count + 1'b1;
                2'b01:   count_nxt = count - 1'b1;
                default: count_nxt = count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < ROB_ENTRIES; i++) begin
                ent_state[i] <= ENT_FREE;
            end
        end else begin
            head  <= head_nxt;
            tail  <= tail_nxt;
            count <= count_nxt;
            for (int i = 0; i < ROB_ENTRIES; i++) begin
                ent_state[i] <= ent_state_nxt[i];
            end
        end
    end

    // Payload fields carry no reset; entry state alone decides whether they are meaningful.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            ent_rd[tail]       <= alloc_rd_i;
            ent_pc[tail]       <= alloc_pc_i;
            ent_is_store[tail] <= alloc_is_store_i;
        end
        if (wb_fire) begin
            ent_data[wb_tag_i] <= wb_data_i;
            ent_exc[wb_tag_i]  <= wb_exc_i;
        end
    end

    // Walk from oldest to youngest so the last match is the closest producer behind tail.
    always_comb begin
        lookup_hit_o   = 1'b0;
        lookup_ready_o = 1'b0;
        lookup_data_o  = '0;
        lk_idx         = head;
        for (int k = 0; k < ROB_ENTRIES; k++) begin
            lk_idx = head + ROB_ENTRY_WIDTH'(k);
            if ((ent_state[lk_idx] != ENT_FREE) && !ent_is_store[lk_idx] &&
                (ent_rd[lk_idx] == lookup_rs_i) && (lookup_rs_i != 5'd0)) begin
                lookup_hit_o   = 1'b1;
                lookup_ready_o = (ent_state[lk_idx] == ENT_DONE);
                lookup_data_o  = ent_data[lk_idx];
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed testbench for reorder_buffer: fill, out-of-order writeback, wrap, forwarding,
// exception retirement and flush/reset recovery against hand-computed expectations.
module tb_reorder_buffer;

    localparam int N  = 8;
    localparam int W  = 3;
    localparam int DW = 32;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          alloc_valid;
    logic          alloc_ready;
    logic [4:0]    alloc_rd;
    logic [AW-1:0] alloc_pc;
    logic          alloc_is_store;
    logic [W-1:0]  alloc_tag;
    logic          wb_valid;
    logic [W-1:0]  wb_tag;
    logic [DW-1:0] wb_data;
    logic          wb_exc;
    logic [4:0]    lookup_rs;
    logic          lookup_hit;
    logic          lookup_ready;
    logic [DW-1:0] lookup_data;
    logic          commit_valid;
    logic          commit_ready;
    logic [4:0]    commit_rd;
    logic [DW-1:0] commit_data;
    logic [AW-1:0] commit_pc;
    logic          commit_is_store;
    logic          commit_exc;
    logic          flush;
    logic [W:0]    count;
    logic          empty;
    logic          full;

    int n_checks = 0;
    int n_pass   = 0;

    reorder_buffer #(
        .ROB_ENTRIES(N), .ROB_ENTRY_WIDTH(W), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_valid_i(alloc_valid), .alloc_ready_o(alloc_ready), .alloc_rd_i(alloc_rd),
        .alloc_pc_i(alloc_pc), .alloc_is_store_i(alloc_is_store), .alloc_tag_o(alloc_tag),
        .wb_valid_i(wb_valid), .wb_tag_i(wb_tag), .wb_data_i(wb_data), .wb_exc_i(wb_exc),
        .lookup_rs_i(lookup_rs), .lookup_hit_o(lookup_hit), .lookup_ready_o(lookup_ready),
        .lookup_data_o(lookup_data),
        .commit_valid_o(commit_valid), .commit_ready_i(commit_ready), .commit_rd_o(commit_rd),
        .commit_data_o(commit_data), .commit_pc_o(commit_pc),
        .commit_is_store_o(commit_is_store), .commit_exc_o(commit_exc),
        .flush_i(flush), .count_o(count), .empty_o(empty), .full_o(full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alloc(input logic [4:0] rd, input logic [AW-1:0] pc, input logic st);
        alloc_valid    = 1'b1;
        alloc_rd       = rd;
        alloc_pc       = pc;
        alloc_is_store = st;
        tick();
        alloc_valid    = 1'b0;
    endtask

    task automatic wb(input logic [W-1:0] tag, input logic [DW-1:0] data, input logic exc);
        wb_valid = 1'b1;
        wb_tag   = tag;
        wb_data  = data;
        wb_exc   = exc;
        tick();
        wb_valid = 1'b0;
        wb_exc   = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; alloc_valid = 1'b0; alloc_rd = '0; alloc_pc = '0; alloc_is_store = 1'b0;
        wb_valid = 1'b0; wb_tag = '0; wb_data = '0; wb_exc = 1'b0; lookup_rs = 5'd3;
        commit_ready = 1'b0; flush = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        #1;
        check("rst_ready", 64'(alloc_ready), 64'd1);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_full", 64'(full), 64'd0);
        check("rst_cvalid", 64'(commit_valid), 64'd0);
        check("rst_hit", 64'(lookup_hit), 64'd0);
        check("rst_tag", 64'(alloc_tag), 64'd0);
        check("rst_count", 64'(count), 64'd0);

        // Fill to capacity, then one ignored alloc
        for (int i = 0; i < N; i++) begin
            alloc_valid = 1'b1; alloc_rd = 5'(i + 1); alloc_pc = 32'h100 + 32'(4 * i);
            alloc_is_store = 1'b0;
            #1;
            check("fill_tag", 64'(alloc_tag), 64'(i));
            tick();
        end
        alloc_rd = 5'd9;
        check("fill_full", 64'(full), 64'd1);
        check("fill_count", 64'(count), 64'd8);
        check("fill_ready", 64'(alloc_ready), 64'd0);
        tick();
        alloc_valid = 1'b0;
        check("ovf_count", 64'(count), 64'd8);
        check("ovf_tag", 64'(alloc_tag), 64'd0);
        lookup_rs = 5'd8;
        #1;
        check("fill_hit", 64'(lookup_hit), 64'd1);
        check("fill_lk_ready", 64'(lookup_ready), 64'd0);
        lookup_rs = 5'd0;

        // Out-of-order writeback, in-order retirement
        wb(3'd2, 32'h22, 1'b0);
        check("ooo_block0", 64'(commit_valid), 64'd0);
        wb(3'd0, 32'h20, 1'b0);
        check("ooo_cv0", 64'(commit_valid), 64'd1);
        check("ooo_rd0", 64'(commit_rd), 64'd1);
        check("ooo_data0", 64'(commit_data), 64'h20);
        check("ooo_pc0", 64'(commit_pc), 64'h100);
        commit_ready = 1'b1; alloc_valid = 1'b1; alloc_rd = 5'd9;
        tick();
        alloc_valid = 1'b0;
        check("nobypass_count", 64'(count), 64'd7);
        check("nobypass_tag", 64'(alloc_tag), 64'd0);
        check("ooo_block1", 64'(commit_valid), 64'd0);
        wb(3'd1, 32'h21, 1'b0);
        check("ooo_cv1", 64'(commit_valid), 64'd1);
        check("ooo_rd1", 64'(commit_rd), 64'd2);
        check("ooo_data1", 64'(commit_data), 64'h21);
        tick();
        check("ooo_cv2", 64'(commit_valid), 64'd1);
        check("ooo_rd2", 64'(commit_rd), 64'd3);
        check("ooo_data2", 64'(commit_data), 64'h22);
        tick();
        commit_ready = 1'b0;
        check("ooo_block3", 64'(commit_valid), 64'd0);
        check("ooo_count", 64'(count), 64'd5);
        wb(3'd3, 32'h33, 1'b0);
        wb(3'd3, 32'h99, 1'b0);
        check("wb_once_cv", 64'(commit_valid), 64'd1);
        check("wb_once_data", 64'(commit_data), 64'h33);
        do_flush();
        check("flush1_count", 64'(count), 64'd0);
        check("flush1_empty", 64'(empty), 64'd1);

        // Wrap-around at occupancy 3: instruction n has rd n+1, pc 0x2000+4n, data 0x1000+n
        for (int n = 0; n < 3; n++) begin
            alloc_valid = 1'b1; alloc_rd = 5'(n + 1); alloc_pc = 32'h2000 + 32'(4 * n);
            #1;
            check("wrap_tag", 64'(alloc_tag), 64'(n));
            tick();
            alloc_valid = 1'b0;
        end
        for (int n = 3; n < 12; n++) begin
            wb(3'((n - 3) % N), 32'h1000 + 32'(n - 3), 1'b0);
            commit_ready = 1'b1; alloc_valid = 1'b1;
            alloc_rd = 5'(n + 1); alloc_pc = 32'h2000 + 32'(4 * n);
            #1;
            check("wrap_cv", 64'(commit_valid), 64'd1);
            check("wrap_rd", 64'(commit_rd), 64'(n - 2));
            check("wrap_pc", 64'(commit_pc), 64'(32'h2000 + 32'(4 * (n - 3))));
            check("wrap_data", 64'(commit_data), 64'(32'h1000 + 32'(n - 3)));
            check("wrap_tag", 64'(alloc_tag), 64'(n % N));
            tick();
            commit_ready = 1'b0; alloc_valid = 1'b0;
            check("wrap_count", 64'(count), 64'd3);
        end
        for (int m = 9; m < 12; m++) begin
            wb(3'(m % N), 32'h1000 + 32'(m), 1'b0);
            commit_ready = 1'b1;
            #1;
            check("drain_rd", 64'(commit_rd), 64'(m + 1));
            tick();
            commit_ready = 1'b0;
        end
        check("drain_empty", 64'(empty), 64'd1);
        check("drain_tag", 64'(alloc_tag), 64'd4);

        // Forwarding from the youngest producer; stores never forward
        do_flush();
        alloc(5'd5, 32'h300, 1'b0);
        alloc(5'd5, 32'h304, 1'b0);
        alloc(5'd5, 32'h308, 1'b1);
        lookup_rs = 5'd5;
        #1;
        check("fwd_hit", 64'(lookup_hit), 64'd1);
        check("fwd_notready", 64'(lookup_ready), 64'd0);
        wb(3'd1, 32'hDEADBEEF, 1'b0);
        check("fwd_ready", 64'(lookup_ready), 64'd1);
        check("fwd_data", 64'(lookup_data), 64'hDEADBEEF);
        wb(3'd0, 32'h11111111, 1'b0);
        check("fwd_youngest", 64'(lookup_data), 64'hDEADBEEF);
        lookup_rs = 5'd0;
        #1;
        check("fwd_r0_hit", 64'(lookup_hit), 64'd0);
        check("fwd_r0_ready", 64'(lookup_ready), 64'd0);
        check("fwd_r0_data", 64'(lookup_data), 64'd0);
        lookup_rs = 5'd7;
        #1;
        check("fwd_miss", 64'(lookup_hit), 64'd0);
        lookup_rs = 5'd0;
        do_flush();

        // Exception at the head flushes the whole buffer on retirement
        for (int i = 0; i < 4; i++) alloc(5'(i + 1), 32'h400 + 32'(4 * i), 1'b0);
        wb(3'd0, 32'h0, 1'b1);
        check("exc_cv", 64'(commit_valid), 64'd1);
        check("exc_flag", 64'(commit_exc), 64'd1);
        commit_ready = 1'b1;
        tick();
        commit_ready = 1'b0;
        check("exc_empty", 64'(empty), 64'd1);
        check("exc_tag", 64'(alloc_tag), 64'd0);
        check("exc_count", 64'(count), 64'd0);
        wb(3'd2, 32'h55, 1'b0);
        check("exc_wb_count", 64'(count), 64'd0);
        check("exc_wb_cv", 64'(commit_valid), 64'd0);
        alloc(5'd6, 32'h500, 1'b0);
        check("exc_realloc_tag", 64'(alloc_tag), 64'd1);
        check("exc_realloc_cv", 64'(commit_valid), 64'd0);

        // Flush mid-operation beats a same-cycle alloc
        do_flush();
        for (int i = 0; i < 5; i++) alloc(5'(i + 1), 32'h600 + 32'(4 * i), 1'b0);
        check("pre_flush_count", 64'(count), 64'd5);
        alloc_valid = 1'b1; flush = 1'b1; alloc_rd = 5'd9;
        tick();
        alloc_valid = 1'b0; flush = 1'b0;
        check("flush_count", 64'(count), 64'd0);
        check("flush_tag", 64'(alloc_tag), 64'd0);
        check("flush_empty", 64'(empty), 64'd1);

        // Reset dominates everything in the same cycle
        for (int i = 0; i < 5; i++) alloc(5'(i + 1), 32'h700 + 32'(4 * i), 1'b0);
        wb(3'd0, 32'h77, 1'b0);
        alloc_valid = 1'b1; rst_n = 1'b0; flush = 1'b1; commit_ready = 1'b1;
        wb_valid = 1'b1; wb_tag = 3'd1;
        tick();
        alloc_valid = 1'b0; rst_n = 1'b1; flush = 1'b0; commit_ready = 1'b0; wb_valid = 1'b0;
        check("rst2_count", 64'(count), 64'd0);
        check("rst2_tag", 64'(alloc_tag), 64'd0);
        check("rst2_empty", 64'(empty), 64'd1);
        check("rst2_ready", 64'(alloc_ready), 64'd1);
        check("rst2_cv", 64'(commit_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
